// File: rtl/counter_responder_pkg.sv
// Shared encodings for the progress controller
// and its counter-side responder.
package counter_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_MAXVAL = 15;

endpackage

// File: rtl/counter_responder_if.sv
// Request/acknowledge bundle between the
// controller (master) and the responder (slave).
interface counter_responder_if #(
  parameter int WIDTH = 4
);

  logic             enable;
  logic             forward;
  logic             clear;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             finish;

  modport master (
    output enable,
    output forward,
    output clear,
    input  out,
    input  busy,
    input  finish
  );

  modport slave (
    input  enable,
    input  forward,
    input  clear,
    output out,
    output busy,
    output finish
  );

endinterface

// File: rtl/counter_responder_step_prescaler.sv
// Tick generator: one tick every PRESCALE enabled
// cycles, restartable so each run begins aligned.
module step_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  assign wrap   = (cnt_q == LAST);
  assign tick_o = en_i & ~restart_i & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_responder.sv
// Counter-side responder: steps the count toward
// the terminal value, then holds finish until release.
module counter_responder
  import counter_responder_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAXVAL   = DEF_MAXVAL,
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  counter_responder_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_W =
    WIDTH'(MAXVAL);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             dir_q;
  logic             dir_d;

  logic             tick;
  logic             in_run;
  logic [WIDTH-1:0] step_v;
  logic [WIDTH-1:0] term_v;
  logic [WIDTH-1:0] start_term;

  assign in_run = (state_q == RUN);

  step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_pre (
    .clk       (clk),
    .rst_n     (reset),
    .restart_i (~in_run),
    .en_i      (in_run),
    .tick_o    (tick)
  );

  assign step_v = (dir_q == DIR_UP) ?
    out_q + WIDTH'(1) : out_q - WIDTH'(1);
  assign term_v = (dir_q == DIR_UP) ?
    MAX_W : '0;
  assign start_term = (bus.forward == DIR_UP) ?
    MAX_W : '0;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          dir_d = bus.forward;
          if (out_q == start_term) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else if (bus.clear) begin
          out_d = '0;
        end
      end
      RUN: begin
        // terminal step wins over a same-edge release
        if (tick && step_v == term_v) begin
          out_d   = step_v;
          state_d = DONE;
        end else if (!bus.enable) begin
          state_d = IDLE;
        end else if (tick) begin
          out_d = step_v;
        end
      end
      DONE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.busy   = in_run;
  assign bus.finish = (state_q == DONE);

endmodule

// File: doc/counter_responder.md
Name: counter_responder

Overview:
- Counter-side responder for the light/progress state-machine controller.
- The controller requests a run with a level `enable` and a direction `forward`. This block steps its count toward the terminal value for that direction, then reports completion on `finish`.
- Finish is held until the controller releases `enable`, giving a 4-phase request/acknowledge handshake.
- `out` feeds the VGA display logic as the current step value.

Parameters:
- WIDTH, 4, bit width of the count `out`.
- MAXVAL, 15, forward terminal value; must be ≤ 2^WIDTH-1 and ≥ 1.
- PRESCALE, 1, clock cycles per count step; must be ≥ 1 (1 = step every cycle).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run request from controller (level).
- forward  input  1  direction: 1 counts up to MAXVAL, 0 counts down to 0. Sampled only at run start.
- clear  input  1  synchronous clear of `out` to 0; honoured only in IDLE.
- out  output  WIDTH  current count value.
- busy  output  1  high while in RUN.
- finish  output  1  high while in DONE (acknowledge).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, out=0, dir=1, prescale count=0, busy=0, finish=0.
- All outputs are registered; busy and finish are decoded from the state register.
- State IDLE:
  - enable=1 → latch dir=forward and clear the prescale count.
  - If out already equals the terminal (MAXVAL when dir=1, 0 when dir=0) → DONE next cycle. Otherwise → RUN.
  - enable=0 and clear=1 → out=0, stay in IDLE.
  - enable=1 has priority over clear.
- State RUN:
  - The prescale count increments each cycle.
  - When it reaches PRESCALE-1, it wraps to 0 and out steps by ±1 per dir.
  - First step occurs PRESCALE cycles after entering RUN.
  - When the stepped value equals the terminal → DONE on the same edge; out is never stepped past the terminal.
  - enable=0 in RUN → abort: IDLE next cycle, out holds its current value, finish is never asserted.
  - forward changes during RUN are ignored; dir stays latched.
  - clear is ignored during RUN.
- State DONE:
  - finish=1 and out is held.
  - enable=0 → IDLE next cycle, finish=0.
  - While enable stays 1 → stay in DONE.
- Width/arithmetic rules:
  - out never wraps: no increment above MAXVAL, no decrement below 0.
  - The prescale counter is sized to clog2(PRESCALE), minimum 1 bit.
- Run latency: for forward from value v, finish rises (MAXVAL-v)*PRESCALE+1 cycles after the enable edge is sampled.
- Simultaneous events:
  - enable fall on the same edge the terminal step happens → DONE is still entered; it leaves to IDLE one cycle later.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package (also used by the controller):
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - the default WIDTH/MAXVAL.
- Sub-module `step_prescaler`: PRESCALE-cycle tick generator with synchronous restart and enable. The main module holds the FSM and the count register.

Test Plan:
- Reset then idle: reset low for 3 cycles, release with enable=0 → out=0, busy=0, finish=0 held for 10 cycles.
- Forward run, PRESCALE=1: enable=1, forward=1 from out=0 →
  - busy rises next cycle;
  - out counts 1..15, one per cycle;
  - finish=1 exactly 16 cycles after enable is sampled.
  - Then enable=0 → finish=0 next cycle, out stays 15.
- Reverse run, PRESCALE=3: from out=15, enable=1, forward=0 →
  - out decrements every 3 cycles to 0;
  - finish after 46 cycles;
  - toggling forward mid-run has no effect.
- Already at terminal: out=0, enable=1, forward=0 → no RUN; finish=1 next cycle, out stays 0.
- Abort and clear: forward run aborted at out=6 (enable=0) → IDLE, out=6, finish never asserted. Then clear=1 → out=0 next cycle.
- Async reset mid-run: assert reset low asynchronously at out=9 → out=0, busy=0 with no clock edge needed. After release, a new run starts from 0.
